// File: rtl/shape_sched_pkg.sv
// Shared types, SFR field layout and helpers for the shape command scheduler.
package shape_sched_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_WRITE,
    S_READ,
    S_CAPTURE,
    S_RESP
  } state_e;

  // Control-register field placement inside the 32-bit SFR word.
  localparam int unsigned SHAPE_LSB = 16;
  localparam int unsigned SHAPE_W   = 2;
  localparam int unsigned OP_LSB    = 0;
  localparam int unsigned OP_W      = 5;

  // Build the control word: shape and operation in their fields, all else zero.
  function automatic logic [31:0] pack_ctrl(input logic [SHAPE_W-1:0] shape,
                                            input logic [OP_W-1:0]    operation);
    logic [31:0] word;
    word                       = '0;
    word[SHAPE_LSB +: SHAPE_W] = shape;
    word[OP_LSB +: OP_W]       = operation;
    return word;
  endfunction

  // Only the two one-hot encodings name a real shape.
  function automatic logic shape_legal(input logic [SHAPE_W-1:0] shape);
    return (shape == 2'b01) || (shape == 2'b10);
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: first requester above last_grant, with wrap.
module rr_arbiter #(
  parameter  int N    = 2,
  localparam int ID_W = $clog2(N)
) (
  input  logic [N-1:0]    req,
  input  logic [ID_W-1:0] last_grant,
  output logic [N-1:0]    grant,
  output logic [ID_W-1:0] grant_id
);

  // Scan N candidates starting at last_grant+1; the first hit wins.
  always_comb begin
    logic            found;
    logic [ID_W-1:0] idx;
    // NOTE: every output gets a default before the loop, otherwise a path
    // with no winner would leave it unassigned and infer a latch.
    grant    = '0;
    grant_id = '0;
    found    = 1'b0;
    idx      = '0;
    for (int k = 1; k <= N; k++) begin
      idx = ID_W'((int'(last_grant) + k) % N);
      if (!found && req[idx]) begin
        grant[idx] = 1'b1;
        grant_id   = idx;
        found      = 1'b1;
      end
    end
  end

endmodule

// File: rtl/shape_cmd_scheduler.sv
// Arbitrates NUM_REQ requesters onto the shape processor's single SFR port:
// one command at a time is written, read back, and returned to its owner.
module shape_cmd_scheduler
  import shape_sched_pkg::*;
#(
  parameter  int NUM_REQ = 2,
  localparam int ID_W    = $clog2(NUM_REQ)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [NUM_REQ-1:0]      req_valid,
  output logic [NUM_REQ-1:0]      req_ready,
  input  logic [NUM_REQ-1:0][1:0] req_shape,
  input  logic [NUM_REQ-1:0][4:0] req_operation,
  output logic                    rsp_valid,
  input  logic                    rsp_ready,
  output logic [ID_W-1:0]         rsp_id,
  output logic [31:0]             rsp_data,
  output logic                    rsp_error,
  output logic                    rsp_rejected,
  output logic                    sp_write,
  output logic [31:0]             sp_write_data,
  output logic                    sp_read,
  input  logic [31:0]             sp_read_data,
  input  logic                    sp_error
);

  state_e          state_q, state_d;
  logic [ID_W-1:0] last_grant_q, last_grant_d;
  logic [ID_W-1:0] id_q, id_d;
  logic [1:0]      shape_q, shape_d;
  logic [4:0]      op_q, op_d;
  logic [31:0]     data_q, data_d;
  logic            err_q, err_d;
  logic            rej_q, rej_d;

  logic [NUM_REQ-1:0] grant;
  logic [ID_W-1:0]    grant_id;

  rr_arbiter #(.N(NUM_REQ)) u_arb (
    .req        (req_valid),
    .last_grant (last_grant_q),
    .grant      (grant),
    .grant_id   (grant_id)
  );

  // Strobes and the response port are pure decodes of the current state.
  assign req_ready     = (state_q == S_IDLE)  ? grant : '0;
  assign sp_write      = (state_q == S_WRITE);
  assign sp_write_data = (state_q == S_WRITE) ? pack_ctrl(shape_q, op_q) : '0;
  assign sp_read       = (state_q == S_READ);
  assign rsp_valid     = (state_q == S_RESP);
  assign rsp_id        = id_q;
  assign rsp_data      = data_q;
  assign rsp_error     = err_q;
  assign rsp_rejected  = rej_q;

  // Next-state and datapath updates for the command sequence.
  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    id_d         = id_q;
    shape_d      = shape_q;
    op_d         = op_q;
    data_d       = data_q;
    err_d        = err_q;
    rej_d        = rej_q;
    unique case (state_q)
      S_IDLE: begin
        if (|req_valid) begin
          last_grant_d = grant_id;
          id_d         = grant_id;
          shape_d      = req_shape[grant_id];
          op_d         = req_operation[grant_id];
          data_d       = '0;
          // A fresh transaction starts with no processor error observed.
          err_d        = 1'b0;
          if (shape_legal(req_shape[grant_id])) begin
            rej_d   = 1'b0;
            state_d = S_WRITE;
          end else begin
            rej_d   = 1'b1;
            state_d = S_RESP;
          end
        end
      end
      S_WRITE: begin
        err_d   = err_q | sp_error;
        state_d = S_READ;
      end
      S_READ: begin
        err_d   = err_q | sp_error;
        state_d = S_CAPTURE;
      end
      S_CAPTURE: begin
        err_d   = err_q | sp_error;
        data_d  = sp_read_data;
        state_d = S_RESP;
      end
      S_RESP: begin
        if (rsp_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State and command registers; reset discards any in-flight command.
  always_ff @(posedge clk) begin
    if (rst) begin
      // NOTE: registers use non-blocking assignments so every flop samples
      // pre-edge values, independent of statement order.
      state_q      <= S_IDLE;
      last_grant_q <= ID_W'(NUM_REQ - 1);
      id_q         <= '0;
      shape_q      <= '0;
      op_q         <= '0;
      data_q       <= '0;
      err_q        <= 1'b0;
      rej_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      id_q         <= id_d;
      shape_q      <= shape_d;
      op_q         <= op_d;
      data_q       <= data_d;
      err_q        <= err_d;
      rej_q        <= rej_d;
    end
  end

endmodule
